// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: state encoding and width helpers shared by the RAM arbiter files.
package ram_arb_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {IDLE = 2'd0, WR = 2'd1, RD1 = 2'd2, RD2 = 2'd3} state_t;
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot pick from a request vector; round-robin unless RAM_ARB_FIXED_PRIO_EN selects fixed priority.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          accept,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);
`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused;
    assign unused = &{1'b0, clk, rst_n, accept};
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                grant = N'(1) << k;
                idx   = PW'(k);
            end
        end
    end
`else
    logic [PW-1:0] ptr;
    // Scan farthest-to-nearest from ptr+1 so the nearest requester overwrites last.
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        j     = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                grant = N'(1) << j;
                idx   = PW'(j);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) ptr <= PW'(N - 1);
        else if (accept) ptr <= idx;
    end
`endif
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM among NUM_REQ requesters (RAM_ARB_FIXED_PRIO_EN: fixed priority).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int A_SIZE  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*A_SIZE-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [WIDTH-1:0]          rsp_rdata,
    output logic [A_SIZE-1:0]         ram_address,
    inout  wire  [WIDTH-1:0]          ram_data,
    output logic                      ram_write,
    output logic                      ram_en
);
    localparam int PW = ptr_w(NUM_REQ);

    state_t              state, nxt;
    logic [NUM_REQ-1:0]  grant;
    logic [PW-1:0]       idx, idx_q;
    logic [A_SIZE-1:0]   addr_q;
    logic [WIDTH-1:0]    wdata_q;
    logic                accept;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant),
        .idx    (idx)
    );

    assign accept    = (state == IDLE) && |req_valid;
    assign req_ready = (state == IDLE) ? grant : '0;

    always_comb begin
        nxt = IDLE;
        if (state == IDLE) nxt = accept ? (req_write[idx] ? WR : RD1) : IDLE;
        else if (state == RD1) nxt = RD2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            state     <= nxt;
            rsp_valid <= (state == WR || state == RD2) ? NUM_REQ'(1) << idx_q : '0;
            if (state == RD2) rsp_rdata <= ram_data;
            if (accept) begin
                idx_q   <= idx;
                addr_q  <= req_addr[idx*A_SIZE +: A_SIZE];
                wdata_q <= req_wdata[idx*WIDTH +: WIDTH];
            end
        end
    end

    // The bus is released everywhere but WR so the RAM can drive it on reads.
    assign ram_en      = state != IDLE;
    assign ram_write   = state == WR;
    assign ram_address = addr_q;
    assign ram_data    = (state == WR) ? wdata_q : 'z;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter against a behavioural RAM and reference memory.
module tb_ram_arbiter;
`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  req_valid = '0, req_write = '0, req_ready, rsp_valid;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [7:0]  rsp_rdata, ram_address;
    wire  [7:0]  ram_data;
    logic        ram_write, ram_en;
    int          n = 0, errs = 0;

    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic [7:0] rd_q = 8'h00;
    logic       rd_valid = 1'b0;

    ram_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_write   (ram_write),
        .ram_en      (ram_en)
    );

    always #5 clk = ~clk;

    // RAM with registered read; it drives the bus in the cycle after a read is sampled.
    always @(posedge clk) begin
        if (ram_en && ram_write) mem[ram_address] <= ram_data;
        rd_q     <= mem[ram_address];
        rd_valid <= ram_en && !ram_write;
    end
    assign ram_data = (rd_valid && ram_en && !ram_write) ? rd_q : 8'hzz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int r, input bit w, input logic [7:0] a, input logic [7:0] d);
        req_valid             = 4'(1) << r;
        req_write[r]          = w;
        req_addr[r*8 +: 8]    = a;
        req_wdata[r*8 +: 8]   = d;
    endtask

    initial begin
        int e, r;
        bit w;
        logic [7:0] a, d;
        tick;
        tick;
        rst_n = 1'b1;
        chk("rst_en", ram_en, 0);
        chk("rst_write", ram_write, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_addr", ram_address, 0);
        chk("rst_ready", req_ready, 0);

        put(0, 1'b1, 8'h10, 8'hA5);
        #1 chk("wr_ready", req_ready, 4'b0001);
        tick;
        req_valid = '0;
        chk("wr_en", ram_en, 1);
        chk("wr_write", ram_write, 1);
        chk("wr_data", ram_data, 8'hA5);
        chk("wr_addr", ram_address, 8'h10);
        chk("wr_busy_ready", req_ready, 0);
        tick;
        chk("wr_rsp", rsp_valid, 4'b0001);
        chk("idle_en", ram_en, 0);
        chk("idle_addr_hold", ram_address, 8'h10);

        put(1, 1'b0, 8'h10, 8'h00);
        #1 chk("rd_ready", req_ready, 4'b0010);
        tick;
        req_valid = '0;
        chk("rd1_en", {ram_en, ram_write}, 2'b10);
        chk("rd1_rsp", rsp_valid, 0);
        tick;
        chk("rd2_bus", ram_data, 8'hA5);
        tick;
        chk("rd_rsp", rsp_valid, 4'b0010);
        chk("rd_rdata", rsp_rdata, 8'hA5);

        put(2, 1'b1, 8'hFF, 8'h3C);
        #1 chk("b2b_ready1", req_ready, 4'b0100);
        tick;
        req_write[2] = 1'b0;
        chk("b2b_wdata", ram_data, 8'h3C);
        tick;
        chk("b2b_rsp1", rsp_valid, 4'b0100);
        chk("b2b_ready2", req_ready, 4'b0100);
        tick;
        req_valid = '0;
        tick;
        chk("b2b_bus", ram_data, 8'h3C);
        tick;
        chk("b2b_rsp2", rsp_valid, 4'b0100);
        chk("b2b_rdata", rsp_rdata, 8'h3C);

        put(1, 1'b0, 8'h03, 8'h00);
        tick;
        req_valid = '0;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("rrst_en", ram_en, 0);
        chk("rrst_rsp", rsp_valid, 0);
        chk("rrst_addr", ram_address, 0);
        chk("rrst_rdata", rsp_rdata, 0);
        tick;
        chk("rrst_rsp2", rsp_valid, 0);

        for (int i = 0; i < 4; i++) begin
            req_addr[i*8 +: 8]  = 8'(i);
            req_wdata[i*8 +: 8] = 8'(8'h50 + i);
        end
        req_valid = 4'hF;
        req_write = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            e = FIXED ? 0 : k % 4;
            chk("rr_ready", req_ready, 4'(1) << e);
            tick;
            chk("rr_addr", ram_address, e);
            chk("rr_data", ram_data, 8'h50 + e);
            tick;
            chk("rr_rsp", rsp_valid, 4'(1) << e);
        end
        req_valid = '0;

        for (int t = 0; t < 1000; t++) begin
            r = int'($urandom_range(3));
            w = 1'($urandom_range(1));
            a = 8'(8'h40 + $urandom_range(15));
            d = 8'($urandom);
            put(r, w, a, d);
            #1 chk("rnd_ready", req_ready, 4'(1) << r);
            tick;
            req_valid = '0;
            if (w) begin
                chk("rnd_wr_ctl", {ram_en, ram_write}, 2'b11);
                chk("rnd_wr_data", ram_data, d);
                ref_mem[a] = d;
                tick;
                chk("rnd_wr_rsp", rsp_valid, 4'(1) << r);
            end else begin
                chk("rnd_rd1_ctl", {ram_en, ram_write}, 2'b10);
                tick;
                chk("rnd_rd2_bus", ram_data, ref_mem[a]);
                tick;
                chk("rnd_rd_rsp", rsp_valid, 4'(1) << r);
                chk("rnd_rd_rdata", rsp_rdata, ref_mem[a]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
